// File: rtl/hilo_unit_if.sv
// Bundle between the HI/LO stage and its surroundings: issue port from the
// pipeline, operand/result port to the multiplier, and architectural HI/LO.
interface hilo_unit_if #(
  parameter int BITS = 32
);
  logic            start;
  logic [1:0]      op;
  logic [BITS-1:0] rs_val;
  logic [BITS-1:0] rt_val;
  logic [BITS-1:0] mul_a;
  logic [BITS-1:0] mul_b;
  logic            mul_unsign;
  logic [BITS-1:0] mul_hi;
  logic [BITS-1:0] mul_lo;
  logic [BITS-1:0] hi;
  logic [BITS-1:0] lo;
  logic            busy;
  logic            done;

  // master is the pipeline plus the combinational multiplier feeding results back
  modport master (
    output start, op, rs_val, rt_val, mul_hi, mul_lo,
    input  mul_a, mul_b, mul_unsign, hi, lo, busy, done
  );

  modport slave (
    input  start, op, rs_val, rt_val, mul_hi, mul_lo,
    output mul_a, mul_b, mul_unsign, hi, lo, busy, done
  );
endinterface

// File: rtl/hilo_unit.sv
// HI/LO stage: holds multiply operands steady for LATENCY cycles, then commits
// the multiplier's hi/lo into HI/LO; also services MTHI/MTLO while idle.
module hilo_unit #(
  parameter int BITS    = 32,
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  hilo_unit_if.slave  bus
);

  if (LATENCY < 1 || LATENCY > 255) begin : g_latency_check
    $error("hilo_unit: LATENCY must be within 1..255");
  end

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_MTHI  = 2'b10;
  localparam logic [1:0] OP_MTLO  = 2'b11;
  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [BITS-1:0] a_q, a_d;
  logic [BITS-1:0] b_q, b_d;
  logic            unsign_q, unsign_d;
  logic [BITS-1:0] hi_q, hi_d;
  logic [BITS-1:0] lo_q, lo_d;
  logic            done_q, done_d;

  // Next-state: issue decode while idle, countdown and commit while busy
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    unsign_d = unsign_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          case (bus.op)
            OP_MULT, OP_MULTU: begin
              a_d      = bus.rs_val;
              b_d      = bus.rt_val;
              unsign_d = bus.op[0];
              cnt_d    = CNT_INIT;
              state_d  = ST_BUSY;
            end
            OP_MTHI: hi_d = bus.rs_val;
            OP_MTLO: lo_d = bus.rs_val;
            default: state_d = ST_IDLE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      // Starts arriving here are dropped; the pipeline holds them until busy falls
      ST_BUSY: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          hi_d    = bus.mul_hi;
          lo_d    = bus.mul_lo;
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset discards any in-flight multiply
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 8'd0;
      a_q      <= '0;
      b_q      <= '0;
      unsign_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      unsign_q <= unsign_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign bus.mul_a      = a_q;
  assign bus.mul_b      = b_q;
  assign bus.mul_unsign = unsign_q;
  assign bus.hi         = hi_q;
  assign bus.lo         = lo_q;
  assign bus.busy       = (state_q == ST_BUSY);
  assign bus.done       = done_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Bench for hilo_unit: unit 0 runs LATENCY=4, unit 1 runs LATENCY=1, each
// against a stand-in multiplier and a transaction-level model of HI/LO.
module tb_hilo_unit;

  localparam logic [1:0] MULT  = 2'b00;
  localparam logic [1:0] MULTU = 2'b01;
  localparam logic [1:0] MTHI  = 2'b10;
  localparam logic [1:0] MTLO  = 2'b11;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  hilo_unit_if #(.BITS(32)) if4 ();
  hilo_unit_if #(.BITS(32)) if1 ();

  hilo_unit #(.BITS(32), .LATENCY(4)) dut4 (.clk(clk), .reset(reset), .bus(if4));
  hilo_unit #(.BITS(32), .LATENCY(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));

  function automatic logic [63:0] mulx(input logic [31:0] a, input logic [31:0] b, input logic uns);
    logic signed [63:0] sa, sb;
    if (uns) return {32'd0, a} * {32'd0, b};
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    return sa * sb;
  endfunction

  logic        i_start[2];
  logic [1:0]  i_op[2];
  logic [31:0] i_rs[2], i_rt[2];
  logic [31:0] o_hi[2], o_lo[2], o_a[2], o_b[2];
  logic        o_uns[2], o_busy[2], o_done[2];
  logic [63:0] p4, p1;

  assign if4.start = i_start[0]; assign if4.op = i_op[0];
  assign if4.rs_val = i_rs[0];   assign if4.rt_val = i_rt[0];
  assign if1.start = i_start[1]; assign if1.op = i_op[1];
  assign if1.rs_val = i_rs[1];   assign if1.rt_val = i_rt[1];
  assign p4 = mulx(if4.mul_a, if4.mul_b, if4.mul_unsign);
  assign p1 = mulx(if1.mul_a, if1.mul_b, if1.mul_unsign);
  assign if4.mul_hi = p4[63:32]; assign if4.mul_lo = p4[31:0];
  assign if1.mul_hi = p1[63:32]; assign if1.mul_lo = p1[31:0];
  assign o_hi[0] = if4.hi; assign o_lo[0] = if4.lo; assign o_a[0] = if4.mul_a;
  assign o_b[0] = if4.mul_b; assign o_uns[0] = if4.mul_unsign;
  assign o_busy[0] = if4.busy; assign o_done[0] = if4.done;
  assign o_hi[1] = if1.hi; assign o_lo[1] = if1.lo; assign o_a[1] = if1.mul_a;
  assign o_b[1] = if1.mul_b; assign o_uns[1] = if1.mul_unsign;
  assign o_busy[1] = if1.busy; assign o_done[1] = if1.done;

  int n_cmp = 0;
  int n_bad = 0;
  int busy_seen[2];
  int done_seen[2];

  // model: remaining cycles of the in-flight multiply and its precomputed product
  logic [31:0] m_hi[2], m_lo[2], m_a[2], m_b[2];
  logic        m_uns[2], m_done[2];
  logic [63:0] m_prod[2];
  int          m_left[2];

  function automatic int lat_of(input int u);
    return (u == 0) ? 4 : 1;
  endfunction

  task automatic chk(input string name, input int u, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s unit%0d t=%0t: got %h want %h", name, u, $time, got, want);
    end
  endtask

  task automatic model_clear(input int u);
    m_hi[u] = 32'd0; m_lo[u] = 32'd0; m_a[u] = 32'd0; m_b[u] = 32'd0;
    m_uns[u] = 1'b0; m_done[u] = 1'b0; m_prod[u] = 64'd0; m_left[u] = 0;
  endtask

  task automatic model_step(input int u);
    m_done[u] = 1'b0;
    if (m_left[u] > 0) begin
      m_left[u]--;
      if (m_left[u] == 0) begin
        {m_hi[u], m_lo[u]} = m_prod[u];
        m_done[u] = 1'b1;
      end
    end else if (i_start[u]) begin
      if (i_op[u] == MULT || i_op[u] == MULTU) begin
        m_a[u] = i_rs[u]; m_b[u] = i_rt[u]; m_uns[u] = (i_op[u] == MULTU);
        m_prod[u] = mulx(i_rs[u], i_rt[u], m_uns[u]);
        m_left[u] = lat_of(u);
      end else if (i_op[u] == MTHI) begin
        m_hi[u] = i_rs[u];
      end else begin
        m_lo[u] = i_rs[u];
      end
    end
  endtask

  always @(posedge reset) begin
    for (int u = 0; u < 2; u++) model_clear(u);
  end

  // Advance the model on each edge, then compare every output just after it
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (reset) model_clear(u);
      else model_step(u);
    end
    #1;
    for (int u = 0; u < 2; u++) begin
      chk("hi", u, 64'(o_hi[u]), 64'(m_hi[u]));
      chk("lo", u, 64'(o_lo[u]), 64'(m_lo[u]));
      chk("mul_a", u, 64'(o_a[u]), 64'(m_a[u]));
      chk("mul_b", u, 64'(o_b[u]), 64'(m_b[u]));
      chk("mul_unsign", u, 64'(o_uns[u]), 64'(m_uns[u]));
      chk("busy", u, 64'(o_busy[u]), 64'(m_left[u] > 0));
      chk("done", u, 64'(o_done[u]), 64'(m_done[u]));
      if (o_busy[u]) busy_seen[u]++;
      if (o_done[u]) done_seen[u]++;
    end
  end

  task automatic step(input int u, input logic s, input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt);
    @(negedge clk);
    i_start[u] = s; i_op[u] = op; i_rs[u] = rs; i_rt[u] = rt;
  endtask

  task automatic clear_counts();
    for (int u = 0; u < 2; u++) begin
      busy_seen[u] = 0;
      done_seen[u] = 0;
    end
  endtask

  initial begin
    bit released;
    for (int u = 0; u < 2; u++) begin
      i_start[u] = 1'b0; i_op[u] = 2'b00; i_rs[u] = 32'd0; i_rt[u] = 32'd0;
    end
    clear_counts();
    repeat (3) @(negedge clk);
    chk("reset_hi", 0, 64'(o_hi[0]), 64'd0);
    chk("reset_busy", 0, 64'(o_busy[0]), 64'd0);
    reset = 1'b0;

    // signed multiply, LATENCY=4
    clear_counts();
    step(0, 1'b1, MULT, 32'hFFFF_FFFE, 32'h0000_0003);
    step(0, 1'b0, MULT, 32'd0, 32'd0);
    repeat (5) @(negedge clk);
    chk("mult_hi", 0, 64'(o_hi[0]), 64'h0000_0000_FFFF_FFFF);
    chk("mult_lo", 0, 64'(o_lo[0]), 64'h0000_0000_FFFF_FFFA);
    chk("mult_busy_cycles", 0, 64'(busy_seen[0]), 64'd4);
    chk("mult_done_pulses", 0, 64'(done_seen[0]), 64'd1);

    // unsigned multiply of the same operands
    clear_counts();
    step(0, 1'b1, MULTU, 32'hFFFF_FFFE, 32'h0000_0003);
    step(0, 1'b0, MULT, 32'd0, 32'd0);
    repeat (5) @(negedge clk);
    chk("multu_hi", 0, 64'(o_hi[0]), 64'h0000_0000_0000_0002);
    chk("multu_lo", 0, 64'(o_lo[0]), 64'h0000_0000_FFFF_FFFA);
    chk("multu_done_pulses", 0, 64'(done_seen[0]), 64'd1);

    // back-to-back moves
    clear_counts();
    step(0, 1'b1, MTHI, 32'h1234_5678, 32'd0);
    step(0, 1'b1, MTLO, 32'h9ABC_DEF0, 32'd0);
    step(0, 1'b0, MULT, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    chk("mthi_hi", 0, 64'(o_hi[0]), 64'h0000_0000_1234_5678);
    chk("mtlo_lo", 0, 64'(o_lo[0]), 64'h0000_0000_9ABC_DEF0);
    chk("move_busy_cycles", 0, 64'(busy_seen[0]), 64'd0);
    chk("move_done_pulses", 0, 64'(done_seen[0]), 64'd0);

    // starts during busy, including the capture cycle, are dropped
    clear_counts();
    step(0, 1'b1, MULT, 32'd7, 32'd6);
    step(0, 1'b0, MULT, 32'd0, 32'd0);
    step(0, 1'b1, MTHI, 32'hDEAD_BEEF, 32'd0);
    step(0, 1'b0, MULT, 32'd0, 32'd0);
    step(0, 1'b1, MTHI, 32'hDEAD_BEEF, 32'd0);
    step(0, 1'b0, MULT, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    chk("ignore_hi", 0, 64'(o_hi[0]), 64'd0);
    chk("ignore_lo", 0, 64'(o_lo[0]), 64'd42);
    chk("ignore_busy_cycles", 0, 64'(busy_seen[0]), 64'd4);
    chk("ignore_done_pulses", 0, 64'(done_seen[0]), 64'd1);

    // async reset mid-multiply after preloading HI/LO
    step(0, 1'b1, MTHI, 32'hAAAA_5555, 32'd0);
    step(0, 1'b1, MTLO, 32'h5555_AAAA, 32'd0);
    step(0, 1'b1, MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step(0, 1'b0, MULT, 32'd0, 32'd0);
    @(negedge clk);
    chk("pre_reset_hi", 0, 64'(o_hi[0]), 64'h0000_0000_AAAA_5555);
    chk("pre_reset_busy", 0, 64'(o_busy[0]), 64'd1);
    reset = 1'b1;
    #1;
    chk("arst_hi", 0, 64'(o_hi[0]), 64'd0);
    chk("arst_lo", 0, 64'(o_lo[0]), 64'd0);
    chk("arst_mul_a", 0, 64'(o_a[0]), 64'd0);
    chk("arst_mul_b", 0, 64'(o_b[0]), 64'd0);
    chk("arst_unsign", 0, 64'(o_uns[0]), 64'd0);
    chk("arst_busy", 0, 64'(o_busy[0]), 64'd0);
    chk("arst_done", 0, 64'(o_done[0]), 64'd0);
    repeat (2) @(negedge clk);
    clear_counts();
    reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("post_reset_done", 0, 64'(done_seen[0]), 64'd0);
    chk("post_reset_lo", 0, 64'(o_lo[0]), 64'd0);

    // LATENCY=1 with the second multiply held by the pipeline until busy drops
    clear_counts();
    step(1, 1'b1, MULT, 32'd3, 32'd5);
    step(1, 1'b1, MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    released = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (!o_busy[1]) begin
        released = 1'b1;
        break;
      end
    end
    chk("l1_busy_released", 1, 64'(released), 64'd1);
    chk("l1_first_lo", 1, 64'(o_lo[1]), 64'd15);
    chk("l1_first_hi", 1, 64'(o_hi[1]), 64'd0);
    step(1, 1'b0, MULT, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    chk("l1_second_hi", 1, 64'(o_hi[1]), 64'd0);
    chk("l1_second_lo", 1, 64'(o_lo[1]), 64'd1);
    chk("l1_busy_cycles", 1, 64'(busy_seen[1]), 64'd2);
    chk("l1_done_pulses", 1, 64'(done_seen[1]), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hilo_unit.md
Name: hilo_unit

Overview:
- Sequential HI/LO stage that sits directly downstream of the combinational multiplier in the ALU.
- Latches MULT/MULTU operands and drives them to the multiplier for a fixed multicycle window, then captures the multiplier's hi/lo outputs into the architectural HI and LO registers.
- Also services MTHI/MTLO writes.
- Raises busy so the pipeline stalls MFHI/MFLO and new multiply issues until the result is committed.

Parameters:
- BITS, 32: operand and HI/LO register width.
- LATENCY, 4: cycles from accepted start to HI/LO update. Legal range is 1..255; the elaboration check fails outside that range.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  issue strobe, sampled on rising clk.
- op  input  2  00 MULT, 01 MULTU, 10 MTHI, 11 MTLO.
- rs_val  input  BITS  first operand; write data for MTHI/MTLO.
- rt_val  input  BITS  second operand.
- mul_a  output  BITS  registered operand a, driven to the multiplier.
- mul_b  output  BITS  registered operand b, driven to the multiplier.
- mul_unsign  output  1  registered unsigned select, driven to the multiplier.
- mul_hi  input  BITS  multiplier high result.
- mul_lo  input  BITS  multiplier low result.
- hi  output  BITS  architectural HI register.
- lo  output  BITS  architectural LO register.
- busy  output  1  multiply in flight; consumers stall on this.
- done  output  1  one-cycle pulse, asserted the cycle after HI/LO capture.

Behaviour:
- Reset (async, any time):
  - hi, lo, mul_a, mul_b = 0; mul_unsign = 0; busy = 0; done = 0.
  - State returns to IDLE and the counter is cleared.
  - An in-flight result is discarded; HI/LO are not written.
- States: IDLE and BUSY. busy is 1 exactly when the state is BUSY; busy is registered.
- IDLE, start=1, op=MULT or MULTU:
  - Next edge: mul_a<=rs_val, mul_b<=rt_val, mul_unsign<=op[0], cnt<=LATENCY-1, state<=BUSY.
  - hi/lo are unchanged.
- IDLE, start=1, op=MTHI: hi<=rs_val next edge; lo unchanged; no busy; no done.
- IDLE, start=1, op=MTLO: lo<=rs_val next edge; hi unchanged; no busy; no done.
- IDLE, start=0: all registers hold.
- BUSY, cnt!=0: cnt<=cnt-1 each edge. mul_a, mul_b and mul_unsign are held stable so the multiplier output settles.
- BUSY, cnt==0: next edge does hi<=mul_hi, lo<=mul_lo, state<=IDLE, done<=1.
- Latency: start accepted at edge k; hi/lo update at edge k+LATENCY; busy is high for exactly LATENCY cycles; done is high for the single cycle after edge k+LATENCY.
- LATENCY=1: the state enters BUSY with cnt=0 and captures on the very next edge.
- Any start while BUSY, including the capture cycle, is ignored with no side effect. The pipeline must hold the instruction until busy=0.
- hi/lo keep their old values throughout BUSY. mul_a/mul_b keep the last operands after completion and are not cleared.
- done is cleared on every edge where it is not being set.
- Multiply arithmetic is owned entirely by the multiplier. This block does no width extension or sign handling beyond driving mul_unsign.

Test Plan:
- BITS=32, LATENCY=4. MULT with rs=0xFFFFFFFE, rt=0x00000003 -> busy for 4 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, and done pulses exactly once.
- MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA. mul_unsign=1 throughout BUSY.
- MTHI with rs=0x12345678, then MTLO with rs=0x9ABCDEF0 on consecutive cycles -> hi=0x12345678, lo=0x9ABCDEF0; busy and done stay 0.
- MULT 7*6, then assert start with MTHI 0xDEADBEEF on the second BUSY cycle and on the capture cycle -> both ignored; final hi=0, lo=42.
- Assert reset two cycles into MULTU 0xFFFFFFFF*0xFFFFFFFF (after HI/LO were preloaded) -> all outputs 0 immediately, asynchronously. After release, no late capture and no done pulse.
- LATENCY=1, back-to-back MULT 3*5 then MULT -1*-1 -> lo=15 after one cycle; the second start is held until busy drops, then hi=0, lo=1.
